// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_t;

  // funct3[1:0] access size codes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  // fault_cause codes
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  localparam int LSU_TIMEOUT_DEF = 16;

  // Byte-enable pattern for an access of the given size at lane 0
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = 8'h01;
      SZ_HALF: size_mask = 8'h03;
      SZ_WORD: size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and extraction/extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [2:0]  i_st_off,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [2:0]  i_ld_off,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata_ext
);

  logic [7:0]  w_mask8;
  logic [63:0] w_mask64;
  logic [63:0] w_shifted;

  // Store: mask the significant LSBs, then move them into the addressed lanes
  always_comb begin
    w_mask8 = size_mask(i_st_size);
    w_mask64 = '0;
    for (int b = 0; b < 8; b++) begin
      w_mask64[b*8 +: 8] = {8{w_mask8[b]}};
    end
    o_be    = w_mask8 << i_st_off;
    o_wdata = (i_wdata & w_mask64) << {i_ld_off_unused_guard(), i_st_off, 3'b000};
  end

  function automatic logic i_ld_off_unused_guard();
    i_ld_off_unused_guard = 1'b0;
  endfunction

  // Load: bring the addressed lanes down to bit 0, then extend by size/sign
  always_comb begin
    w_shifted = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_funct3[1:0])
      SZ_BYTE: o_rdata_ext = i_ld_funct3[2] ? {56'd0, w_shifted[7:0]}
                                            : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_rdata_ext = i_ld_funct3[2] ? {48'd0, w_shifted[15:0]}
                                            : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_rdata_ext = i_ld_funct3[2] ? {32'd0, w_shifted[31:0]}
                                            : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_rdata_ext = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time, with alignment/legality
// checking, an access timeout and a one-shot fault pulse per rejected request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_tmo_cnt;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_be;
  logic [2:0]  r_ld_f3;
  logic [2:0]  r_off;
  logic [63:0] r_read_data;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic        r_mask;
  logic [63:0] r_mask_addr;

  logic        w_req, w_illegal, w_misalign, w_masked, w_start_ok, w_reject;
  logic        w_launch, w_reject_fire, w_abort, w_load_done;
  logic [7:0]  w_be;
  logic [63:0] w_wdata, w_ld_ext;

  // Request qualification from the live pipeline inputs
  always_comb begin
    w_req     = MemRead | MemWrite;
    w_illegal = (MemRead & MemWrite) | (MemRead & (funct3 == 3'b111)) |
                (MemWrite & funct3[2]);
    case (funct3[1:0])
      SZ_HALF: w_misalign = ALUResult[0];
      SZ_WORD: w_misalign = |ALUResult[1:0];
      SZ_DBL:  w_misalign = |ALUResult[2:0];
      default: w_misalign = 1'b0;
    endcase
    w_masked   = r_mask & w_req & (ALUResult == r_mask_addr);
    w_start_ok = w_req & ~w_illegal & ~w_misalign & ~w_masked;
    w_reject   = w_req & (w_illegal | w_misalign) & ~w_masked;
  end

  lsu_align u_align (
    .i_st_size   (funct3[1:0]),
    .i_st_off    (ALUResult[2:0]),
    .i_wdata     (WriteData),
    .i_ld_funct3 (r_ld_f3),
    .i_ld_off    (r_off),
    .i_rdata     (mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_ld_ext)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and combinational control
  always_comb begin
    w_state_nxt   = r_state;
    stall         = 1'b0;
    w_launch      = 1'b0;
    w_reject_fire = 1'b0;
    w_abort       = 1'b0;
    w_load_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          stall       = 1'b1;
          w_launch    = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else if (w_reject) begin
          w_reject_fire = 1'b1;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (mem_ack) begin
          w_load_done = ~r_we;
          w_state_nxt = ST_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory request registers, timeout counter and load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_ld_f3     <= '0;
      r_off       <= '0;
      r_tmo_cnt   <= '0;
      r_read_data <= '0;
    end else begin
      if (w_launch) begin
        r_we      <= MemWrite;
        r_addr    <= {ALUResult[63:3], 3'b000};
        r_off     <= ALUResult[2:0];
        r_ld_f3   <= funct3;
        r_be      <= w_be;
        r_wdata   <= MemWrite ? w_wdata : 64'd0;
        r_tmo_cnt <= '0;
      end else if (r_state == ST_ACCESS && !mem_ack) begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
      if (w_load_done) r_read_data <= w_ld_ext;
    end
  end

  // Fault pulse and request mask so a held bad request faults only once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault       <= 1'b0;
      r_fault_cause <= FC_NONE;
      r_mask        <= 1'b0;
      r_mask_addr   <= '0;
    end else begin
      r_fault       <= w_reject_fire | w_abort;
      r_fault_cause <= w_abort ? FC_TIMEOUT :
                       w_reject_fire ? (w_illegal ? FC_ILLEGAL : FC_MISALIGN) :
                       FC_NONE;
      if (w_reject_fire || w_abort) begin
        r_mask      <= 1'b1;
        r_mask_addr <= ALUResult;
      end else if (r_mask && !(w_req && ALUResult == r_mask_addr)) begin
        r_mask <= 1'b0;
      end
    end
  end

  assign mem_req     = (r_state == ST_ACCESS);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_be      = r_be;
  assign ReadData    = r_read_data;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [63:0] ALUResult, WriteData, mem_rdata;
  logic        mem_ack;
  logic [63:0] ReadData, mem_addr, mem_wdata;
  logic        stall, fault, mem_req, mem_we;
  logic [1:0]  fault_cause;
  logic [7:0]  mem_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .stall(stall), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; funct3 = 0; ALUResult = 0; WriteData = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Load with ack in the first ACCESS cycle; ReadData checked in DONE
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
    drive(1, 0, f3, addr, 0);
    chk({tag, "_stall_req"}, stall, 1);
    step();
    chk({tag, "_mem_req"}, mem_req, 1);
    mem_ack = 1; mem_rdata = rdata;
    step();
    mem_ack = 0; MemRead = 0;
    #1;
    chk({tag, "_rdata"}, ReadData, exp);
    chk({tag, "_stall_done"}, stall, 0);
    step();
  endtask

  initial begin
    int hi;
    logic [63:0] held;
    reset = 1;
    idle_inputs();
    step();
    chk("rst_rdata", ReadData, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_stall", stall, 0);
    step();
    reset = 0;
    step();

    // LD 0x10: stall in request cycle and ACCESS, data in DONE (N+2)
    drive(1, 0, 3'b011, 64'h10, 0);
    chk("ld_stall_n", stall, 1);
    chk("ld_req_n", mem_req, 0);
    step();
    chk("ld_stall_n1", stall, 1);
    chk("ld_req_n1", mem_req, 1);
    chk("ld_addr", mem_addr, 64'h10);
    chk("ld_we", mem_we, 0);
    chk("ld_be", mem_be, 8'hFF);
    mem_ack = 1; mem_rdata = 64'h1122334455667788;
    step();
    mem_ack = 0; MemRead = 0;
    #1;
    chk("ld_rdata", ReadData, 64'h1122334455667788);
    chk("ld_stall_n2", stall, 0);
    chk("ld_req_n2", mem_req, 0);
    step();
    chk("ld_stall_n3", stall, 0);

    run_load("lb",  3'b000, 64'h13, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lbu", 3'b100, 64'h13, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    run_load("lh",  3'b001, 64'h02, 64'h0000_0000_ABCD_0000, 64'hFFFF_FFFF_FFFF_ABCD);
    run_load("lhu", 3'b101, 64'h02, 64'h0000_0000_ABCD_0000, 64'h0000_0000_0000_ABCD);
    run_load("lw",  3'b010, 64'h04, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    run_load("lwu", 3'b110, 64'h04, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);

    // SH 0x06: upper lanes, junk above the halfword discarded, ReadData untouched
    drive(0, 1, 3'b001, 64'h06, 64'hDEAD_0000_0000_BEEF);
    step();
    chk("sh_req", mem_req, 1);
    chk("sh_we", mem_we, 1);
    chk("sh_be", mem_be, 8'hC0);
    chk("sh_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_addr", mem_addr, 64'h0);
    mem_ack = 1; mem_rdata = 64'h5555_5555_5555_5555;
    step();
    mem_ack = 0; MemWrite = 0;
    #1;
    chk("sh_rdata_hold", ReadData, 64'h0000_0000_8765_4321);
    step();

    // SB 0x05
    drive(0, 1, 3'b000, 64'h05, 64'hFFFF_FFFF_FFFF_FFAB);
    step();
    chk("sb_be", mem_be, 8'h20);
    chk("sb_wdata", mem_wdata, 64'h0000_AB00_0000_0000);
    mem_ack = 1;
    step();
    mem_ack = 0; MemWrite = 0;
    step();

    // LW 0x02 misaligned: one fault pulse, no access, held request masked
    drive(1, 0, 3'b010, 64'h02, 0);
    chk("mis_stall", stall, 0);
    step();
    chk("mis_fault", fault, 1);
    chk("mis_cause", fault_cause, 2'b01);
    chk("mis_req", mem_req, 0);
    chk("mis_stall2", stall, 0);
    step();
    chk("mis_fault_once", fault, 0);
    chk("mis_req2", mem_req, 0);
    step();
    chk("mis_fault_held", fault, 0);
    MemRead = 0;
    step();

    // Illegal forms
    drive(1, 1, 3'b011, 64'h08, 0);
    step();
    chk("ill_rw_fault", fault, 1);
    chk("ill_rw_cause", fault_cause, 2'b11);
    chk("ill_rw_req", mem_req, 0);
    idle_inputs(); step();
    drive(1, 0, 3'b111, 64'h08, 0);
    step();
    chk("ill_ld7_cause", fault_cause, 2'b11);
    idle_inputs(); step();
    drive(0, 1, 3'b100, 64'h08, 0);
    step();
    chk("ill_st_fault", fault, 1);
    chk("ill_st_cause", fault_cause, 2'b11);
    idle_inputs(); step();

    // Stray ack in IDLE ignored
    mem_ack = 1; mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    mem_ack = 0;
    step();
    chk("stray_ack_rdata", ReadData, 64'h0000_0000_8765_4321);
    chk("stray_ack_req", mem_req, 0);

    // Timeout: mem_req high for exactly 16 cycles then fault cause 10
    held = ReadData;
    drive(1, 0, 3'b011, 64'h20, 0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!mem_req) break;
      hi++;
    end
    chk("tmo_req_cycles", 64'(hi), 64'd16);
    chk("tmo_fault", fault, 1);
    chk("tmo_cause", fault_cause, 2'b10);
    chk("tmo_stall", stall, 0);
    chk("tmo_rdata", ReadData, held);
    step();
    chk("tmo_fault_once", fault, 0);
    chk("tmo_no_retry", mem_req, 0);
    idle_inputs(); step();

    // Reset in 2nd ACCESS cycle, late ack after release
    drive(1, 0, 3'b011, 64'h30, 0);
    step();
    step();
    chk("rma_req_before", mem_req, 1);
    reset = 1; MemRead = 0;
    #1;
    chk("rma_req_async", mem_req, 0);
    step();
    reset = 0;
    mem_ack = 1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
    step();
    mem_ack = 0;
    step();
    chk("rma_req", mem_req, 0);
    chk("rma_fault", fault, 0);
    chk("rma_rdata", ReadData, 0);
    chk("rma_addr", mem_addr, 0);
    chk("rma_be", mem_be, 0);
    chk("rma_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles in ACCESS waiting for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  load request from Control for the current instruction.
REQ-005 MemWrite  input  1  store request from Control for the current instruction.
REQ-006 funct3  input  3  access size/sign (instruction[14:12]).
REQ-007 ALUResult  input  64  effective byte address.
REQ-008 WriteData  input  64  store data (rs2), LSBs significant.
REQ-009 ReadData  output  64  extended load result, valid in DONE.
REQ-010 stall  output  1  holds PC/register writeback while an access is in flight.
REQ-011 fault  output  1  one-cycle pulse on a rejected or aborted access.
REQ-012 fault_cause  output  2  01 misaligned, 10 timeout, 11 illegal; valid with fault.
REQ-013 mem_req / mem_we  output  1 each  memory request / write enable.
REQ-014 mem_addr  output  64  doubleword-aligned address (ALUResult with [2:0] = 0).
REQ-015 mem_wdata / mem_be  output  64 / 8  lane-steered store data / byte enables.
REQ-016 mem_ack / mem_rdata  input  1 / 64  access complete / raw doubleword read data.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; the unit SHALL accept one access at a time.
REQ-018 IDLE: MemRead xor MemWrite, legal and aligned -> ACCESS; mem_addr, mem_we, mem_be, mem_wdata registered on that edge.
REQ-019 stall SHALL be combinational: 1 in IDLE with a valid legal aligned request, 1 throughout ACCESS, 0 in DONE.
REQ-020 ACCESS: mem_req=1 and all mem_* outputs held stable until mem_ack; on mem_ack, load data is extracted and registered, -> DONE.
REQ-021 DONE: exactly one cycle, ReadData valid, stall=0, no new access started; -> IDLE.
REQ-022 Minimum latency (ack in first ACCESS cycle): request seen cycle N, ReadData valid cycle N+2.
REQ-023 Sizes: funct3[1:0] 00 byte, 01 half, 10 word, 11 double; funct3[2]=1 zero-extends, else sign-extends to 64 bits.
REQ-024 Alignment: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0; otherwise fault, cause 01, no memory access, stall=0.
REQ-025 Illegal: MemRead and MemWrite both 1, load funct3=111, or store funct3[2]=1 -> fault, cause 11, no access.
REQ-026 Store lanes: mem_be = size mask shifted by addr[2:0]; WriteData LSBs replicated/shifted into the same lanes.
REQ-027 Load extract: mem_rdata shifted right by 8*addr[2:0], masked to size, then extended.
REQ-028 Timeout: a counter SHALL clear on entering ACCESS; when it reaches TIMEOUT without mem_ack, mem_req is dropped, fault pulses with cause 10, -> IDLE; ReadData is unchanged.
REQ-029 mem_ack arriving outside ACCESS SHALL be ignored.
REQ-030 Fault on one instruction SHALL NOT re-fire while the same request is still held; fault pulses once per rejected instruction (one cycle, then IDLE with the request masked until MemRead/MemWrite drop or the address changes).
REQ-031 ReadData SHALL hold its last value outside DONE; a store SHALL NOT modify ReadData.

Reset
REQ-032 Reset asserted SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadData=0, fault=0, fault_cause=00, timeout counter=0.
REQ-033 Reset mid-ACCESS SHALL abandon the transaction with no fault; a later mem_ack is ignored per REQ-029.

Structure
REQ-034 Shared package lsu_pkg: state enum, funct3 size codes, fault_cause codes, default TIMEOUT.
REQ-035 One combinational sub-module lsu_align: store lane steering/byte enables and load extraction/extension.

Verification
REQ-036 LD addr 0x10, mem_rdata 0x1122334455667788, ack 1st ACCESS cycle -> ReadData 0x1122334455667788 two cycles after request, stall high exactly 2 cycles.
REQ-037 LB addr 0x13, mem_rdata byte3=0x80 -> ReadData 0xFFFFFFFFFFFFFF80; LBU same -> 0x0000000000000080.
REQ-038 SH addr 0x06, WriteData 0xBEEF -> mem_be 0xC0, mem_wdata[63:48]=0xBEEF, mem_we=1.
REQ-039 LW addr 0x02 -> fault one cycle, cause 01, mem_req never asserted, stall 0.
REQ-040 LD with mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 ACCESS cycles, fault cause 10, state IDLE.
REQ-041 Reset asserted in 2nd ACCESS cycle, late mem_ack after release -> all outputs at reset values, no fault, ReadData 0.
